// File: rtl/dcache_line_memory.sv
// dcache_line_memory
//
// Line-granular backing store for the data cache miss/write-back port.
// One 256-bit line request is accepted at a time and held for LATENCY cycles.
// The write is then committed, or the read line is returned, together with a
// single-cycle ack_o pulse.
//
// Parameters:
//   LATENCY  cycles from acceptance to ack_o (1..255)
//   LINE_AW  line-index width; the array holds 2**LINE_AW lines
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   enable_i     request valid, held by the requester until ack_o
//   write_i      1 = write line, 0 = read line (sampled at acceptance)
//   addr_i       byte address of the line; index = addr_i[5+LINE_AW-1:5]
//   data_i       write-back line (sampled at acceptance)
//   ack_o        one-cycle completion pulse
//   data_o       last read line; held across writes and idle periods
//   proto_err_o  sticky protocol-error flag
//
// Optional feature: define DMEM_PROTOCOL_CHECK_EN to build the requester
// protocol checker. Without it, proto_err_o is tied low.
module dcache_line_memory #(
    parameter int unsigned LATENCY = 10,
    parameter int unsigned LINE_AW = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         proto_err_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic [LINE_AW-1:0]   idx_q;
    logic                 write_q;
    logic [255:0]         wdata_q;
    logic [255:0]         rdata_q;
    logic                 accept;
    logic                 commit;

    // No reset on the array: contents are undefined until written.
    logic [255:0] mem_q [2**LINE_AW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    accept  = 1'b1;
                    cnt_d   = 8'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    commit  = 1'b1;
                    ack_d   = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            ack_q   <= 1'b0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            if (accept) begin
                idx_q   <= addr_i[5+LINE_AW-1:5];
                write_q <= write_i;
                wdata_q <= data_i;
            end
            if (commit && !write_q) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    // A reset mid-transaction returns state to StIdle, so commit cannot fire.
    always_ff @(posedge clk_i) begin
        if (commit && write_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = rdata_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
    logic [31:0] addr_q;
    logic        proto_err_q;
    logic        proto_viol;

    always_comb begin
        proto_viol = 1'b0;
        if (state_q == StIdle && enable_i && addr_i[4:0] != 5'd0) begin
            proto_viol = 1'b1;
        end
        if (state_q == StBusy &&
            (!enable_i || write_i != write_q || addr_i != addr_q)) begin
            proto_viol = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            addr_q      <= 32'd0;
            proto_err_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= addr_i;
            end
            if (proto_viol) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign proto_err_o = proto_err_q;
`else
    // Offset and aliased upper address bits carry no function without the checker.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5+LINE_AW], addr_i[4:0]};
    assign proto_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_line_memory.sv
module tb_dcache_line_memory;

    localparam int LAT = 10;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic [31:0]  addr_i = 32'd0;
    logic [255:0] data_i = '0;
    logic         ack_o;
    logic [255:0] data_o;
    logic         proto_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [255:0] LINE_A5 = {32{8'hA5}};

`ifdef DMEM_PROTOCOL_CHECK_EN
    localparam logic [255:0] PROTO_EXP = 256'd1;
`else
    localparam logic [255:0] PROTO_EXP = 256'd0;
`endif

    dcache_line_memory #(
        .LATENCY(LAT),
        .LINE_AW(9)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .write_i    (write_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .ack_o      (ack_o),
        .data_o     (data_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [255:0] got,
                               input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Counts edges until ack_o is seen; bounded.
    task automatic wait_ack(output int lat);
        lat = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            lat++;
            if (ack_o) break;
        end
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wd);
        int lat;
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = addr;
        data_i   = wd;
        tick();                         // acceptance edge T0
        wait_ack(lat);
        check_value({tag, "_lat"}, 256'(lat), 256'(LAT));
        enable_i = 1'b0;
        tick();
        check_value({tag, "_ack1"}, 256'(ack_o), 256'd0);
    endtask

    initial begin
        int lat;

        tick();
        check_value("rst_ack", 256'(ack_o), 256'd0);
        check_value("rst_data", data_o, 256'd0);
        check_value("rst_perr", 256'(proto_err_o), 256'd0);
        rst_i = 1'b1;
        tick();

        // Preload line 3, then read it.
        run_txn("wr60", 1'b1, 32'h60, LINE_A5);
        check_value("wr60_data_hold", data_o, 256'd0);
        run_txn("rd60", 1'b0, 32'h60, '0);
        check_value("rd60_data", data_o, LINE_A5);

        // Write then read; data_o holds across the write.
        run_txn("wr400", 1'b1, 32'h400, 256'h1234);
        check_value("wr400_data_hold", data_o, LINE_A5);
        run_txn("rd400", 1'b0, 32'h400, '0);
        check_value("rd400_data", data_o, 256'h1234);

        // Write-back then refill; 0x8020 and 0x20 share line index 1.
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h8020;
        data_i   = 256'hC0FFEE;
        tick();
        wait_ack(lat);
        check_value("chain_lat1", 256'(lat), 256'(LAT));
        write_i = 1'b0;
        addr_i  = 32'h20;
        tick();
        check_value("chain_ack_gap", 256'(ack_o), 256'd0);
        wait_ack(lat);
        check_value("chain_ack_spacing", 256'(lat + 1), 256'(LAT + 2));
        check_value("chain_data", data_o, 256'hC0FFEE);
        enable_i = 1'b0;
        tick();

        // Aliasing: 0x4040 and 0x40 both map to line 2.
        run_txn("wr4040", 1'b1, 32'h0000_4040, 256'hBEEF);
        run_txn("rd40", 1'b0, 32'h0000_0040, '0);
        check_value("alias_data", data_o, 256'hBEEF);

        // Reset mid-write: line 0x80 must keep its old zero contents.
        run_txn("wr80_zero", 1'b1, 32'h80, 256'd0);
        enable_i = 1'b1;
        write_i  = 1'b1;
        addr_i   = 32'h80;
        data_i   = 256'hDEAD;
        tick();                         // T0
        for (int i = 0; i < 5; i++) tick();
        rst_i = 1'b0;
        #1;
        check_value("rstmid_ack", 256'(ack_o), 256'd0);
        check_value("rstmid_data", data_o, 256'd0);
        enable_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack_o) check_value("rstmid_no_ack", 256'(ack_o), 256'd0);
        end
        rst_i = 1'b1;
        tick();
        run_txn("rd80", 1'b0, 32'h80, '0);
        check_value("rd80_data", data_o, 256'd0);

        // Reset with enable held: request accepted again after release.
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 32'h60;
        tick();
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check_value("rsthold_ack", 256'(ack_o), 256'd0);
        rst_i = 1'b1;                   // release between edges, enable still high
        wait_ack(lat);
        check_value("rsthold_lat", 256'(lat), 256'(LAT + 1));
        check_value("rsthold_data", data_o, LINE_A5);
        enable_i = 1'b0;
        tick();

        // Protocol violation: enable dropped before edge T0+3.
        enable_i = 1'b1;
        write_i  = 1'b0;
        addr_i   = 32'h400;
        tick();                         // T0
        tick();
        tick();                         // T0+2
        check_value("perr_before", 256'(proto_err_o), 256'd0);
        enable_i = 1'b0;
        tick();                         // T0+3
        check_value("perr_set", 256'(proto_err_o), PROTO_EXP);
        enable_i = 1'b1;
        wait_ack(lat);
        check_value("perr_lat", 256'(lat + 3), 256'(LAT));
        check_value("perr_data", data_o, 256'h1234);
        enable_i = 1'b0;
        tick();
        tick();
        check_value("perr_sticky", 256'(proto_err_o), PROTO_EXP);
        rst_i = 1'b0;
        #1;
        check_value("perr_cleared", 256'(proto_err_o), 256'd0);
        rst_i = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_line_memory.md
# dcache_line_memory

Line-granular data memory serving the data cache's miss/write-back port. Accepts one 256-bit line request at a time over an enable/write/ack handshake, holds it for a fixed access latency, then either commits the write-back line or returns the requested line with a single-cycle acknowledge. Sits directly downstream of the data cache controller and is the only backing store for data lines in the design.

## Interface
- LATENCY, 10: cycles from request acceptance to ack_o; legal range 1..255.
- LINE_AW, 9: line-index width; array depth is 2**LINE_AW lines of 256 bits.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- enable_i  input  1  request valid; held high by requester until ack_o.
- write_i  input  1  1 = write line, 0 = read line; sampled at acceptance.
- addr_i  input  32  byte address of line; bits [4:0] are zero for legal requests.
- data_i  input  256  write-back line; sampled at acceptance.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line; valid from the ack_o cycle until the next read completes.
- proto_err_o  output  1  sticky protocol-error flag (see Configuration).

## Operation
- States: IDLE, BUSY, ACK. Reset state IDLE.
- IDLE: at a rising edge with enable_i=1, accept: latch index = addr_i[5+LINE_AW-1:5], write_i and data_i; load cnt = LATENCY-1; go BUSY. enable_i=0: stay IDLE.
- BUSY: cnt != 0: cnt decrements, inputs ignored. cnt == 0: at that edge perform the access, set ack_o=1, go ACK.
  - Write: array[index] <= latched data_i; data_o unchanged.
  - Read: data_o <= array[index].
- ACK: at next edge ack_o=0, go IDLE. Requests are never accepted in ACK; at least one IDLE cycle separates transactions.
- Address bits [31:5+LINE_AW] are ignored; addresses differing only there alias to the same line.
- Array has no reset; contents undefined until written or preloaded by the bench.
- Back-to-back write-back then refill (requester drops write_i on ack, keeps enable_i high) is accepted on the IDLE cycle following ack as a read, with no lost cycle beyond that IDLE.
- Read of a line written by the immediately preceding transaction returns the new data.

## Timing
- Reset values: ack_o=0, data_o=0, proto_err_o=0, cnt=0, state IDLE.
- Acceptance at edge T0 -> ack_o high from edge T0+LATENCY to edge T0+LATENCY+1; read data_o updates at edge T0+LATENCY.
- Transaction period with enable_i held high: LATENCY+2 cycles.
- rst_i asserted mid-transaction: immediate abort; pending write not committed; outputs return to reset values; enable_i still high after release is accepted as a fresh request.
- data_o is stable across write transactions and idle periods.

## Configuration
- DMEM_PROTOCOL_CHECK_EN defined: proto_err_o sets (sticky until reset) when, in BUSY, enable_i is 0, or write_i or addr_i differs from its value at acceptance; or when an accepted addr_i has [4:0] != 0. Transaction completes normally regardless.
- Undefined: checker logic absent; proto_err_o tied to 0.

## Test plan
- Read after preload, LATENCY=10: array[3]=256'hA5..A5, enable_i=1, write_i=0, addr_i=32'h60 at T0 -> ack_o only during cycle T0+10, data_o=256'hA5..A5 from T0+10.
- Write then read: write 256'h1234 to addr 32'h400, then read 32'h400 -> read returns 256'h1234; data_o unchanged during the write.
- Write-back + refill chaining: write line 32'h8020, on ack drop write_i keeping enable_i, addr 32'h20 -> read accepted at ack+1, second ack 12 cycles after first.
- Aliasing, LINE_AW=9: write 256'hBEEF at 32'h0000_4040 -> read of 32'h0000_0040 returns 256'hBEEF.
- Reset mid-write: rst_i low at T0+5 of write 256'hDEAD to 32'h80 over 256'h0 -> ack_o never pulses, line 32'h80 still 256'h0, data_o=0.
- With DMEM_PROTOCOL_CHECK_EN: drop enable_i at T0+3 -> proto_err_o=1 from T0+3 edge, ack still at T0+10, flag held until reset; without macro proto_err_o stays 0.
